hazard_controller: RTL and testbench

//  Pipeline sequencing for the 5-stage MIPS core. Works alongside the forwarding unit.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/sat_counter.sv | 27 ++
 rtl/hazard_controller.sv | 172 +++++++++++++++++
 tb/tb_hazard_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline control: PC source select and the
// hazard controller's sequencing states.
package mips_pkg;

  typedef enum logic [1:0] {
    PCSrc_PCPlus4 = 2'b00,
    PCSrc_Jump    = 2'b01,
    PCSrc_JumpR   = 2'b10,
    PCSrc_Branch  = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_MEMWAIT = 2'b01,
    ST_ERROR   = 2'b10
  } hz_state_e;

  // $zero is never a real producer, so it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// stall/flush performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q;

  // Count register: clear wins, then increment unless already saturated.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      value_q <= '0;
    end else if (inc_i && (value_q != {W{1'b1}})) begin
      value_q <= value_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      value_q <= value_q;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/freeze sequencing for the 5-stage MIPS pipe: load-use and
// jr-operand stalls, control flushes, memory-wait freeze with timeout.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_RegRsAddr,
  input  logic [4:0]       IFID_RegRtAddr,
  input  logic             IFID_UsesRt,
  input  logic [1:0]       IFID_PCSrc,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_RegWrAddr,
  input  logic             EXMEM_MemRead,
  input  logic             EXMEM_MemWrite,
  input  logic [4:0]       EXMEM_RegWrAddr,
  input  logic             EX_BranchTaken,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             Pipe_Freeze,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;

  logic memacc_s, lu_s, jrh_s, is_jump_s;
  logic r_pc_write_s, r_ifid_write_s, r_ifid_flush_s, r_idex_flush_s, r_ctrl_flush_s;
  logic apply_rules_s, freeze_s, ctrl_flush_s;

  assign memacc_s  = EXMEM_MemRead | EXMEM_MemWrite;
  assign lu_s      = IDEX_MemRead &
                     (reg_match(IDEX_RegWrAddr, IFID_RegRsAddr) |
                      (IFID_UsesRt & reg_match(IDEX_RegWrAddr, IFID_RegRtAddr)));
  assign jrh_s     = (IFID_PCSrc == PCSrc_JumpR) &
                     ((IDEX_RegWrite & reg_match(IDEX_RegWrAddr, IFID_RegRsAddr)) |
                      (EXMEM_MemRead & reg_match(EXMEM_RegWrAddr, IFID_RegRsAddr)));
  assign is_jump_s = (IFID_PCSrc == PCSrc_Jump) | (IFID_PCSrc == PCSrc_JumpR);

  // Branch/stall/jump priority chain, shared by RUN and the MEMWAIT release cycle.
  always_comb begin
    r_pc_write_s   = 1'b1;
    r_ifid_write_s = 1'b1;
    r_ifid_flush_s = 1'b0;
    r_idex_flush_s = 1'b0;
    r_ctrl_flush_s = 1'b0;
    if (EX_BranchTaken) begin
      r_ifid_flush_s = 1'b1;
      r_idex_flush_s = 1'b1;
      r_ctrl_flush_s = 1'b1;
    end else if (lu_s || jrh_s) begin
      r_pc_write_s   = 1'b0;
      r_ifid_write_s = 1'b0;
      r_idex_flush_s = 1'b1;
    end else if (is_jump_s) begin
      r_ifid_flush_s = 1'b1;
      r_ctrl_flush_s = 1'b1;
    end else begin
      r_ctrl_flush_s = 1'b0;
    end
  end

  // Next-state logic: memory wait tracking and timeout into ERROR.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    timeout_d     = timeout_q;
    apply_rules_s = 1'b0;
    freeze_s      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (memacc_s && !Mem_Ready) begin
          freeze_s = 1'b1;
          state_d  = ST_MEMWAIT;
          wait_d   = {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          apply_rules_s = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (Mem_Ready) begin
          apply_rules_s = 1'b1;
          state_d       = ST_RUN;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          freeze_s  = 1'b1;
          state_d   = ST_ERROR;
          timeout_d = 1'b1;
        end else begin
          freeze_s = 1'b1;
          wait_d   = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_ERROR: begin
        freeze_s = 1'b1;
      end
      default: begin
        freeze_s = 1'b1;
        state_d  = ST_ERROR;
      end
    endcase
  end

  // Control outputs; reset forces bubbles into both front-end registers.
  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    Pipe_Freeze  = 1'b0;
    ctrl_flush_s = 1'b0;
    if (reset) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (freeze_s) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      Pipe_Freeze = 1'b1;
    end else if (apply_rules_s) begin
      PC_Write     = r_pc_write_s;
      IFID_Write   = r_ifid_write_s;
      IFID_Flush   = r_ifid_flush_s;
      IDEX_Flush   = r_idex_flush_s;
      ctrl_flush_s = r_ctrl_flush_s;
    end else begin
      ctrl_flush_s = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign Mem_Timeout = timeout_q & ~reset;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (~reset & ~PC_Write),
    .value_o (Stall_Count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (~reset & ctrl_flush_s),
    .value_o (Flush_Count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller (small counters and timeout so
// saturation and the ERROR path are reachable quickly).
module tb_hazard_controller;

  localparam int CNT_W = 4;
  localparam int MEM_TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] IFID_RegRsAddr, IFID_RegRtAddr;
  logic IFID_UsesRt;
  logic [1:0] IFID_PCSrc;
  logic IDEX_MemRead, IDEX_RegWrite;
  logic [4:0] IDEX_RegWrAddr;
  logic EXMEM_MemRead, EXMEM_MemWrite;
  logic [4:0] EXMEM_RegWrAddr;
  logic EX_BranchTaken, Mem_Ready;
  logic PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze, Mem_Timeout;
  logic [CNT_W-1:0] Stall_Count, Flush_Count;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  hazard_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .IFID_RegRsAddr(IFID_RegRsAddr), .IFID_RegRtAddr(IFID_RegRtAddr),
    .IFID_UsesRt(IFID_UsesRt), .IFID_PCSrc(IFID_PCSrc),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
    .IDEX_RegWrAddr(IDEX_RegWrAddr),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .EXMEM_RegWrAddr(EXMEM_RegWrAddr),
    .EX_BranchTaken(EX_BranchTaken), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .Pipe_Freeze(Pipe_Freeze), .Mem_Timeout(Mem_Timeout),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    IFID_RegRsAddr = 5'd1; IFID_RegRtAddr = 5'd2; IFID_UsesRt = 1'b0;
    IFID_PCSrc = 2'b00; IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0;
    IDEX_RegWrAddr = 5'd0; EXMEM_MemRead = 1'b0; EXMEM_MemWrite = 1'b0;
    EXMEM_RegWrAddr = 5'd0; EX_BranchTaken = 1'b0; Mem_Ready = 1'b1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze, Mem_Timeout} !== 6'b001100) begin
      err_cnt++; $display("FAIL reset_ctrl got=%b exp=001100", {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze, Mem_Timeout}); end
    tick();
    reset = 1'b0;
    #1;
    vec_cnt++; if ({Stall_Count, Flush_Count} !== 8'h00) begin
      err_cnt++; $display("FAIL reset_counters got=%h/%h exp=0/0", Stall_Count, Flush_Count); end
    vec_cnt++; if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze} !== 5'b11000) begin
      err_cnt++; $display("FAIL idle_ctrl got=%b exp=11000", {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze}); end
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_RegWrAddr = 5'd8;
    IFID_RegRsAddr = 5'd9; IFID_RegRtAddr = 5'd8; IFID_UsesRt = 1'b0;
    #1;
    vec_cnt++; if (PC_Write !== 1'b1) begin
      err_cnt++; $display("FAIL lu_rt_unused PC_Write got=%b exp=1", PC_Write); end
    IFID_UsesRt = 1'b1;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Flush} !== 4'b0001) begin
      err_cnt++; $display("FAIL lu_stall got=%b exp=0001", {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush}); end
    tick();
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_RegWrAddr = 5'd0;
    EXMEM_MemRead = 1'b1; EXMEM_RegWrAddr = 5'd8; Mem_Ready = 1'b1;
    #1;
    vec_cnt++; if ({PC_Write, IDEX_Flush} !== 2'b10) begin
      err_cnt++; $display("FAIL lu_release got=%b exp=10", {PC_Write, IDEX_Flush}); end
    tick();
    vec_cnt++; if ({Stall_Count, Flush_Count} !== {4'd1, 4'd0}) begin
      err_cnt++; $display("FAIL lu_counts got=%0d/%0d exp=1/0", Stall_Count, Flush_Count); end
  endtask

  task automatic test_jr_after_load();
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_RegWrAddr = 5'd31;
    IFID_RegRsAddr = 5'd31; IFID_PCSrc = 2'b10;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Flush, IDEX_Flush} !== 3'b001) begin
      err_cnt++; $display("FAIL jr_stall1 got=%b exp=001", {PC_Write, IFID_Flush, IDEX_Flush}); end
    tick();
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_RegWrAddr = 5'd0;
    EXMEM_MemRead = 1'b1; EXMEM_RegWrAddr = 5'd31; Mem_Ready = 1'b1;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Flush, IDEX_Flush} !== 3'b001) begin
      err_cnt++; $display("FAIL jr_stall2 got=%b exp=001", {PC_Write, IFID_Flush, IDEX_Flush}); end
    tick();
    EXMEM_MemRead = 1'b0; EXMEM_RegWrAddr = 5'd0;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Flush} !== 4'b1110) begin
      err_cnt++; $display("FAIL jr_flush got=%b exp=1110", {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush}); end
    tick();
    set_idle();
    vec_cnt++; if ({Stall_Count, Flush_Count} !== {4'd2, 4'd1}) begin
      err_cnt++; $display("FAIL jr_counts got=%0d/%0d exp=2/1", Stall_Count, Flush_Count); end
  endtask

  task automatic test_jr_after_alu();
    do_reset();
    IDEX_RegWrite = 1'b1; IDEX_RegWrAddr = 5'd5; IFID_RegRsAddr = 5'd5; IFID_PCSrc = 2'b10;
    #1;
    vec_cnt++; if ({PC_Write, IDEX_Flush} !== 2'b01) begin
      err_cnt++; $display("FAIL jr_alu_stall got=%b exp=01", {PC_Write, IDEX_Flush}); end
    tick();
    IDEX_RegWrite = 1'b0; IDEX_RegWrAddr = 5'd0;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Flush} !== 2'b11) begin
      err_cnt++; $display("FAIL jr_alu_flush got=%b exp=11", {PC_Write, IFID_Flush}); end
    tick();
    set_idle();
    vec_cnt++; if ({Stall_Count, Flush_Count} !== {4'd1, 4'd1}) begin
      err_cnt++; $display("FAIL jr_alu_counts got=%0d/%0d exp=1/1", Stall_Count, Flush_Count); end
  endtask

  task automatic test_branch_over_lu();
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_RegWrAddr = 5'd8; IFID_RegRsAddr = 5'd8; EX_BranchTaken = 1'b1;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Flush} !== 4'b1111) begin
      err_cnt++; $display("FAIL branch_flush got=%b exp=1111", {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush}); end
    tick();
    set_idle();
    vec_cnt++; if ({Stall_Count, Flush_Count} !== {4'd0, 4'd1}) begin
      err_cnt++; $display("FAIL branch_counts got=%0d/%0d exp=0/1", Stall_Count, Flush_Count); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    EXMEM_MemWrite = 1'b1; Mem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      EX_BranchTaken = (i == 1);
      #1;
      vec_cnt++; if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze} !== 5'b00001) begin
        err_cnt++; $display("FAIL memwait_freeze cyc=%0d got=%b exp=00001", i, {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze}); end
      tick();
    end
    Mem_Ready = 1'b1; EX_BranchTaken = 1'b1;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze} !== 5'b11110) begin
      err_cnt++; $display("FAIL memwait_release got=%b exp=11110", {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze}); end
    tick();
    set_idle();
    vec_cnt++; if ({Stall_Count, Flush_Count} !== {4'd3, 4'd1}) begin
      err_cnt++; $display("FAIL memwait_counts got=%0d/%0d exp=3/1", Stall_Count, Flush_Count); end
  endtask

  task automatic test_timeout();
    do_reset();
    EXMEM_MemRead = 1'b1; EXMEM_RegWrAddr = 5'd3; Mem_Ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    vec_cnt++; if ({Mem_Timeout, Pipe_Freeze} !== 2'b01) begin
      err_cnt++; $display("FAIL timeout_early got=%b exp=01", {Mem_Timeout, Pipe_Freeze}); end
    tick();
    vec_cnt++; if (Mem_Timeout !== 1'b1) begin
      err_cnt++; $display("FAIL timeout_set got=%b exp=1", Mem_Timeout); end
    Mem_Ready = 1'b1;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Write, Pipe_Freeze, Mem_Timeout} !== 4'b0011) begin
      err_cnt++; $display("FAIL error_sticky got=%b exp=0011", {PC_Write, IFID_Write, Pipe_Freeze, Mem_Timeout}); end
    tick();
    vec_cnt++; if (Stall_Count !== 4'd6) begin
      err_cnt++; $display("FAIL error_stalls got=%0d exp=6", Stall_Count); end
    set_idle();
    reset = 1'b1;
    #1;
    vec_cnt++; if ({Mem_Timeout, Pipe_Freeze} !== 2'b00) begin
      err_cnt++; $display("FAIL timeout_reset_cyc got=%b exp=00", {Mem_Timeout, Pipe_Freeze}); end
    tick();
    reset = 1'b0;
    #1;
    vec_cnt++; if ({PC_Write, Pipe_Freeze, Mem_Timeout, Stall_Count, Flush_Count} !== {3'b100, 8'h00}) begin
      err_cnt++; $display("FAIL timeout_cleared got=%b exp=10000000000", {PC_Write, Pipe_Freeze, Mem_Timeout, Stall_Count, Flush_Count}); end
  endtask

  task automatic test_boundaries();
    do_reset();
    IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_RegWrAddr = 5'd0;
    IFID_RegRsAddr = 5'd0; IFID_RegRtAddr = 5'd0; IFID_UsesRt = 1'b1;
    #1;
    vec_cnt++; if ({PC_Write, IDEX_Flush} !== 2'b10) begin
      err_cnt++; $display("FAIL zero_reg_lu got=%b exp=10", {PC_Write, IDEX_Flush}); end
    IDEX_MemRead = 1'b0; IFID_PCSrc = 2'b10;
    #1;
    vec_cnt++; if ({PC_Write, IFID_Flush} !== 2'b11) begin
      err_cnt++; $display("FAIL zero_reg_jr got=%b exp=11", {PC_Write, IFID_Flush}); end
    set_idle();
    IDEX_MemRead = 1'b1; IDEX_RegWrAddr = 5'd4; IFID_RegRsAddr = 5'd4;
    for (int i = 0; i < 20; i++) tick();
    vec_cnt++; if ({Stall_Count, Flush_Count} !== {4'd15, 4'd0}) begin
      err_cnt++; $display("FAIL stall_saturate got=%0d/%0d exp=15/0", Stall_Count, Flush_Count); end
    EX_BranchTaken = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    vec_cnt++; if ({Stall_Count, Flush_Count} !== {4'd15, 4'd15}) begin
      err_cnt++; $display("FAIL flush_saturate got=%0d/%0d exp=15/15", Stall_Count, Flush_Count); end
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_jr_after_load();
    test_jr_after_alu();
    test_branch_over_lu();
    test_mem_wait();
    test_timeout();
    test_boundaries();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
